memory_arbiter: RTL and testbench

- Shares one unified memory port between the instruction-fetch requester and the load/store data requester of the core.
- Supports one outstanding transaction at a time. Data has priority over fetch, with a starvation guard for fetch.
- Requests are latched at grant. Each response is routed back to the requester that issued it, one registered cycle later.
- Sits between the core's fetch/LSU front ends and the memory or bus interface.

---
 rtl/memory_arbiter_if.sv | 51 +++++
 rtl/memory_arbiter.sv | 134 +++++++++++++
 tb/tb_memory_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side handshakes around memory_arbiter.
// The arbiter uses the slave view; the core front ends and memory model use master.
interface memory_arbiter_if #(
    parameter int XLEN = 32
);
    logic                fetch_request_valid;
    logic                fetch_request_ready;
    logic [XLEN-1:0]     fetch_address;
    logic                fetch_response_valid;
    logic [XLEN-1:0]     fetch_response_data;

    logic                data_request_valid;
    logic                data_request_ready;
    logic                data_write_enable;
    logic [XLEN-1:0]     data_address;
    logic [XLEN-1:0]     data_write_data;
    logic [XLEN/8-1:0]   data_write_strobe;
    logic                data_response_valid;
    logic [XLEN-1:0]     data_response_data;

    logic                memory_request_valid;
    logic                memory_request_ready;
    logic                memory_write_enable;
    logic [XLEN-1:0]     memory_address;
    logic [XLEN-1:0]     memory_write_data;
    logic [XLEN/8-1:0]   memory_write_strobe;
    logic                memory_response_valid;
    logic [XLEN-1:0]     memory_response_data;

    modport slave (
        input  fetch_request_valid, fetch_address,
        input  data_request_valid, data_write_enable, data_address,
        input  data_write_data, data_write_strobe,
        input  memory_request_ready, memory_response_valid, memory_response_data,
        output fetch_request_ready, fetch_response_valid, fetch_response_data,
        output data_request_ready, data_response_valid, data_response_data,
        output memory_request_valid, memory_write_enable, memory_address,
        output memory_write_data, memory_write_strobe
    );

    modport master (
        output fetch_request_valid, fetch_address,
        output data_request_valid, data_write_enable, data_address,
        output data_write_data, data_write_strobe,
        output memory_request_ready, memory_response_valid, memory_response_data,
        input  fetch_request_ready, fetch_response_valid, fetch_response_data,
        input  data_request_ready, data_response_valid, data_response_data,
        input  memory_request_valid, memory_write_enable, memory_address,
        input  memory_write_data, memory_write_strobe
    );
endinterface

// File: rtl/memory_arbiter.sv
// Two-requester arbiter for a single unified memory port: one transaction in flight,
// data-first priority with a starvation guard that eventually lets a waiting fetch through.
module memory_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input logic             clk,
    input logic             n_rst,
    memory_arbiter_if.slave bus
);
    localparam int         SW    = XLEN / 8;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        WAIT_RESPONSE
    } state_t;

    typedef enum logic {
        OWNER_FETCH,
        OWNER_DATA
    } owner_t;

    state_t          state;
    state_t          state_next;
    owner_t          owner;
    logic [3:0]      starve_cnt;

    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [SW-1:0]   mem_strb;

    logic            fetch_rsp_vld_p1;
    logic [XLEN-1:0] fetch_rsp_data_p1;
    logic            data_rsp_vld_p1;
    logic [XLEN-1:0] data_rsp_data_p1;

    logic            fetch_wins;
    logic            grant_fetch;
    logic            grant_data;
    logic            rsp_take;

    // Grant decision: a starved fetch beats data, otherwise data beats fetch.
    always_comb begin
        fetch_wins  = bus.fetch_request_valid &&
                      ((starve_cnt == LIMIT) || !bus.data_request_valid);
        grant_fetch = n_rst && (state == IDLE) && fetch_wins;
        grant_data  = n_rst && (state == IDLE) && bus.data_request_valid && !fetch_wins;
        rsp_take    = (state == WAIT_RESPONSE) && bus.memory_response_valid;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:          if (grant_fetch || grant_data)  state_next = REQUEST;
            REQUEST:       if (bus.memory_request_ready)   state_next = WAIT_RESPONSE;
            WAIT_RESPONSE: if (bus.memory_response_valid)  state_next = IDLE;
            default:                                       state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant stage: latch the winning request and update the starvation counter.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            owner      <= OWNER_FETCH;
            starve_cnt <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_strb   <= '0;
        end else if (grant_fetch) begin
            owner      <= OWNER_FETCH;
            starve_cnt <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= bus.fetch_address;
            mem_wdata  <= '0;
            mem_strb   <= '0;
        end else if (grant_data) begin
            owner      <= OWNER_DATA;
            mem_we     <= bus.data_write_enable;
            mem_addr   <= bus.data_address;
            mem_wdata  <= bus.data_write_data;
            mem_strb   <= bus.data_write_strobe;
            if (!bus.fetch_request_valid) begin
                starve_cnt <= '0;
            end else if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

    // Response stage: one registered cycle back to whichever requester owns the transaction.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            fetch_rsp_vld_p1  <= 1'b0;
            fetch_rsp_data_p1 <= '0;
            data_rsp_vld_p1   <= 1'b0;
            data_rsp_data_p1  <= '0;
        end else begin
            fetch_rsp_vld_p1 <= rsp_take && (owner == OWNER_FETCH);
            data_rsp_vld_p1  <= rsp_take && (owner == OWNER_DATA);
            if (rsp_take) begin
                if (owner == OWNER_FETCH) begin
                    fetch_rsp_data_p1 <= bus.memory_response_data;
                end else begin
                    // Stores only get an acknowledge, never the bus read data.
                    data_rsp_data_p1 <= mem_we ? '0 : bus.memory_response_data;
                end
            end
        end
    end

    assign bus.fetch_request_ready  = grant_fetch;
    assign bus.data_request_ready   = grant_data;
    assign bus.memory_request_valid = (state == REQUEST);
    assign bus.memory_write_enable  = mem_we;
    assign bus.memory_address       = mem_addr;
    assign bus.memory_write_data    = mem_wdata;
    assign bus.memory_write_strobe  = mem_strb;
    assign bus.fetch_response_valid = fetch_rsp_vld_p1;
    assign bus.fetch_response_data  = fetch_rsp_data_p1;
    assign bus.data_response_valid  = data_rsp_vld_p1;
    assign bus.data_response_data   = data_rsp_data_p1;
endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed transaction table, hand-written corner
// sequences and a randomized run against a transaction-level reference model.
module tb_memory_arbiter;
    localparam int LIMIT = 4;

    logic clk;
    logic n_rst;
    int   tests;
    int   fails;

    memory_arbiter_if #(.XLEN(32)) bus ();

    memory_arbiter #(
        .XLEN(32),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_fetch;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          rdy_dly;
        int          rsp_dly;
        logic [31:0] rdata;
        bit          exp_we;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rsp;
    } txn_t;

    txn_t tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_fready"}, {31'd0, bus.fetch_request_ready}, 32'd0);
        check({tag, "_dready"}, {31'd0, bus.data_request_ready}, 32'd0);
        check({tag, "_mreq"}, {31'd0, bus.memory_request_valid}, 32'd0);
        check({tag, "_mwe"}, {31'd0, bus.memory_write_enable}, 32'd0);
        check({tag, "_maddr"}, bus.memory_address, 32'd0);
        check({tag, "_mwdata"}, bus.memory_write_data, 32'd0);
        check({tag, "_mstrb"}, {28'd0, bus.memory_write_strobe}, 32'd0);
        check({tag, "_frsp"}, {31'd0, bus.fetch_response_valid}, 32'd0);
        check({tag, "_drsp"}, {31'd0, bus.data_response_valid}, 32'd0);
        check({tag, "_fdata"}, bus.fetch_response_data, 32'd0);
        check({tag, "_ddata"}, bus.data_response_data, 32'd0);
    endtask

    // Entered in the REQUEST cycle; returns #1 into the response-pulse cycle.
    task automatic mem_complete(input logic [31:0] rdata);
        bus.memory_request_ready = 1'b1;
        tick();
        bus.memory_request_ready  = 1'b0;
        bus.memory_response_valid = 1'b1;
        bus.memory_response_data  = rdata;
        tick();
        bus.memory_response_valid = 1'b0;
        #1;
    endtask

    task automatic run_txn(input string tag, input txn_t t);
        int n;
        n = 0;
        if (t.is_fetch) begin
            bus.fetch_request_valid = 1'b1;
            bus.fetch_address       = t.addr;
            bus.data_write_enable   = 1'b1;
            bus.data_write_strobe   = 4'hF;
            bus.data_write_data     = 32'hBAD0BAD0;
            bus.data_address        = 32'hFFFF0000;
        end else begin
            bus.data_request_valid  = 1'b1;
            bus.data_write_enable   = t.we;
            bus.data_address        = t.addr;
            bus.data_write_data     = t.wdata;
            bus.data_write_strobe   = t.strb;
            bus.fetch_address       = 32'h0BAD0BAD;
        end
        #1;
        while (!(bus.fetch_request_ready || bus.data_request_ready) && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, {30'd0, bus.fetch_request_ready, bus.data_request_ready},
              t.is_fetch ? 32'd2 : 32'd1);
        tick();
        bus.fetch_request_valid = 1'b0;
        bus.data_request_valid  = 1'b0;
        for (int i = 0; i <= t.rdy_dly; i++) begin
            bus.memory_request_ready = (i == t.rdy_dly);
            #1;
            check({tag, "_mreq"}, {31'd0, bus.memory_request_valid}, 32'd1);
            check({tag, "_maddr"}, bus.memory_address, t.addr);
            check({tag, "_mwe"}, {31'd0, bus.memory_write_enable}, {31'd0, t.exp_we});
            check({tag, "_mwdata"}, bus.memory_write_data, t.exp_wdata);
            check({tag, "_mstrb"}, {28'd0, bus.memory_write_strobe}, {28'd0, t.exp_strb});
            tick();
        end
        bus.memory_request_ready = 1'b0;
        for (int i = 0; i <= t.rsp_dly; i++) begin
            bus.memory_response_valid = (i == t.rsp_dly);
            bus.memory_response_data  = (i == t.rsp_dly) ? t.rdata : 32'h5A5A5A5A;
            #1;
            check({tag, "_mreq_wait"}, {31'd0, bus.memory_request_valid}, 32'd0);
            check({tag, "_early_rsp"}, {30'd0, bus.fetch_response_valid, bus.data_response_valid}, 32'd0);
            tick();
        end
        bus.memory_response_valid = 1'b0;
        #1;
        check({tag, "_rsp_route"}, {30'd0, bus.fetch_response_valid, bus.data_response_valid},
              t.is_fetch ? 32'd2 : 32'd1);
        check({tag, "_rsp_data"}, t.is_fetch ? bus.fetch_response_data : bus.data_response_data,
              t.exp_rsp);
        tick();
        check({tag, "_rsp_once"}, {30'd0, bus.fetch_response_valid, bus.data_response_valid}, 32'd0);
    endtask

    // Randomized run: the model tracks the in-flight transaction and the count of
    // consecutive data grants that passed over a waiting fetch.
    task automatic random_run(input int cycles);
        bit          fv_pend, dv_pend, busy, accepted, own_fetch;
        bit          exp_fp, exp_dp, m_we;
        logic [31:0] m_addr, m_wdata, exp_fd, exp_dd;
        logic [3:0]  m_strb;
        int          passed_over, winner;
        fv_pend = 0; dv_pend = 0; busy = 0; accepted = 0; own_fetch = 0;
        exp_fp = 0; exp_dp = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_strb = 0;
        exp_fd = 0; exp_dd = 0; passed_over = 0;
        for (int c = 0; c < cycles; c++) begin
            if (!fv_pend) begin
                fv_pend           = ($urandom_range(0, 1) == 0);
                bus.fetch_address = $urandom;
            end
            if (!dv_pend) begin
                dv_pend               = ($urandom_range(0, 1) == 0);
                bus.data_write_enable = $urandom_range(0, 1);
                bus.data_address      = $urandom;
                bus.data_write_data   = $urandom;
                bus.data_write_strobe = 4'($urandom);
            end
            bus.fetch_request_valid   = fv_pend;
            bus.data_request_valid    = dv_pend;
            bus.memory_request_ready  = $urandom_range(0, 1);
            bus.memory_response_valid = ($urandom_range(0, 2) == 0);
            bus.memory_response_data  = $urandom;
            #1;
            winner = 0;
            if (!busy) begin
                if (fv_pend && passed_over >= LIMIT) winner = 1;
                else if (dv_pend)                    winner = 2;
                else if (fv_pend)                    winner = 1;
            end
            check("rnd_fready", {31'd0, bus.fetch_request_ready}, {31'd0, winner == 1});
            check("rnd_dready", {31'd0, bus.data_request_ready}, {31'd0, winner == 2});
            check("rnd_mreq", {31'd0, bus.memory_request_valid}, {31'd0, busy && !accepted});
            if (busy && !accepted) begin
                check("rnd_maddr", bus.memory_address, m_addr);
                check("rnd_mwe", {31'd0, bus.memory_write_enable}, {31'd0, m_we});
                check("rnd_mwdata", bus.memory_write_data, m_wdata);
                check("rnd_mstrb", {28'd0, bus.memory_write_strobe}, {28'd0, m_strb});
            end
            check("rnd_frsp", {31'd0, bus.fetch_response_valid}, {31'd0, exp_fp});
            check("rnd_drsp", {31'd0, bus.data_response_valid}, {31'd0, exp_dp});
            if (exp_fp) check("rnd_fdata", bus.fetch_response_data, exp_fd);
            if (exp_dp) check("rnd_ddata", bus.data_response_data, exp_dd);
            exp_fp = 0;
            exp_dp = 0;
            if (busy && accepted) begin
                if (bus.memory_response_valid) begin
                    if (own_fetch) begin
                        exp_fp = 1;
                        exp_fd = bus.memory_response_data;
                    end else begin
                        exp_dp = 1;
                        exp_dd = m_we ? 32'd0 : bus.memory_response_data;
                    end
                    busy = 0;
                end
            end else if (busy) begin
                if (bus.memory_request_ready) accepted = 1;
            end else if (winner == 1) begin
                busy = 1; accepted = 0; own_fetch = 1;
                m_addr = bus.fetch_address; m_we = 0; m_wdata = 0; m_strb = 0;
                passed_over = 0;
                fv_pend = 0;
            end else if (winner == 2) begin
                busy = 1; accepted = 0; own_fetch = 0;
                m_addr = bus.data_address; m_we = bus.data_write_enable;
                m_wdata = bus.data_write_data; m_strb = bus.data_write_strobe;
                passed_over = fv_pend ? ((passed_over < LIMIT) ? passed_over + 1 : LIMIT) : 0;
                dv_pend = 0;
            end
            tick();
        end
        bus.fetch_request_valid   = 1'b0;
        bus.data_request_valid    = 1'b0;
        bus.memory_request_ready  = 1'b0;
        bus.memory_response_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] grant_seq[6];
        tests = 0;
        fails = 0;
        n_rst = 1'b0;
        bus.fetch_request_valid   = 1'b0;
        bus.fetch_address         = '0;
        bus.data_request_valid    = 1'b0;
        bus.data_write_enable     = 1'b0;
        bus.data_address          = '0;
        bus.data_write_data       = '0;
        bus.data_write_strobe     = '0;
        bus.memory_request_ready  = 1'b0;
        bus.memory_response_valid = 1'b0;
        bus.memory_response_data  = '0;

        tbl[0] = '{1, 0, 32'h100, 32'h0, 4'h0, 0, 0, 32'h00500093, 0, 4'h0, 32'h0, 32'h00500093};
        tbl[1] = '{0, 1, 32'h200, 32'hDEADBEEF, 4'hF, 3, 0, 32'h13579BDF, 1, 4'hF, 32'hDEADBEEF, 32'h0};
        tbl[2] = '{0, 0, 32'h304, 32'h77777777, 4'h0, 1, 2, 32'h12345678, 0, 4'h0, 32'h77777777, 32'h12345678};
        tbl[3] = '{0, 1, 32'h040, 32'h0000CAFE, 4'h3, 0, 1, 32'hFFFFFFFF, 1, 4'h3, 32'h0000CAFE, 32'h0};
        tbl[4] = '{1, 0, 32'h104, 32'h0, 4'h0, 2, 1, 32'hFEDCBA98, 0, 4'h0, 32'h0, 32'hFEDCBA98};

        repeat (3) tick();
        check_all_zero("reset");
        n_rst = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_txn($sformatf("tbl%0d", i), tbl[i]);
        end

        // Simultaneous requests: data first, fetch granted in the data response cycle.
        bus.fetch_request_valid = 1'b1;
        bus.fetch_address       = 32'h500;
        bus.data_request_valid  = 1'b1;
        bus.data_write_enable   = 1'b0;
        bus.data_address        = 32'h600;
        #1;
        check("both_ready", {30'd0, bus.fetch_request_ready, bus.data_request_ready}, 32'd1);
        tick();
        bus.data_request_valid = 1'b0;
        check("both_maddr_d", bus.memory_address, 32'h600);
        mem_complete(32'h11111111);
        check("both_drsp", {30'd0, bus.fetch_response_valid, bus.data_response_valid}, 32'd1);
        check("both_ddata", bus.data_response_data, 32'h11111111);
        check("both_fready_next", {31'd0, bus.fetch_request_ready}, 32'd1);
        tick();
        bus.fetch_request_valid = 1'b0;
        check("both_maddr_f", bus.memory_address, 32'h500);
        mem_complete(32'hAAAA5555);
        check("both_frsp", {30'd0, bus.fetch_response_valid, bus.data_response_valid}, 32'd2);
        check("both_fdata", bus.fetch_response_data, 32'hAAAA5555);
        tick();

        // Starvation guard: four data grants pass a waiting fetch, then fetch, then data again.
        grant_seq = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd2, 32'd1};
        bus.fetch_request_valid = 1'b1;
        bus.fetch_address       = 32'h800;
        bus.data_request_valid  = 1'b1;
        bus.data_address        = 32'h900;
        #1;
        for (int g = 0; g < 6; g++) begin
            check($sformatf("starve_grant%0d", g),
                  {30'd0, bus.fetch_request_ready, bus.data_request_ready}, grant_seq[g]);
            tick();
            mem_complete($urandom);
        end
        bus.fetch_request_valid = 1'b0;
        bus.data_request_valid  = 1'b0;
        tick();

        // Reset while waiting for the response: the late response must vanish.
        bus.data_request_valid = 1'b1;
        bus.data_write_enable  = 1'b0;
        bus.data_address       = 32'h700;
        #1;
        check("rst_mid_grant", {31'd0, bus.data_request_ready}, 32'd1);
        tick();
        bus.data_request_valid   = 1'b0;
        bus.memory_request_ready = 1'b1;
        tick();
        bus.memory_request_ready = 1'b0;
        n_rst = 1'b0;
        tick();
        check_all_zero("rst_mid");
        n_rst = 1'b1;
        bus.memory_response_valid = 1'b1;
        bus.memory_response_data  = 32'h77777777;
        tick();
        bus.memory_response_valid = 1'b0;
        check("rst_late_rsp", {30'd0, bus.fetch_response_valid, bus.data_response_valid}, 32'd0);
        tick();
        check_all_zero("rst_after");
        bus.fetch_request_valid = 1'b1;
        #1;
        check("rst_idle", {31'd0, bus.fetch_request_ready}, 32'd1);
        bus.fetch_request_valid = 1'b0;
        tick();

        // Stray memory response while idle.
        bus.memory_response_valid = 1'b1;
        bus.memory_response_data  = 32'h99999999;
        tick();
        bus.memory_response_valid = 1'b0;
        #1;
        check("stray_rsp", {30'd0, bus.fetch_response_valid, bus.data_response_valid}, 32'd0);
        check("stray_mreq", {31'd0, bus.memory_request_valid}, 32'd0);
        bus.data_request_valid = 1'b1;
        #1;
        check("stray_idle", {31'd0, bus.data_request_ready}, 32'd1);
        bus.data_request_valid = 1'b0;
        tick();

        n_rst = 1'b0;
        repeat (2) tick();
        n_rst = 1'b1;
        random_run(3000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
